// File: rtl/dcache_pkg.sv
// Shared geometry, field helpers and FSM state type for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int INDEX_BITS  = 3;
    localparam int OFFSET_BITS = 2;

    localparam int TAG_W      = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int NUM_LINES  = 2 ** INDEX_BITS;
    localparam int BLOCK_W    = DATA_W * (2 ** OFFSET_BITS);
    localparam int MADDR_W    = TAG_W + INDEX_BITS;
    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_BITS;
    localparam int TAG_LSB    = OFFSET_BITS + INDEX_BITS;

    typedef logic [ADDR_W-1:0]      addr_t;
    typedef logic [DATA_W-1:0]      byte_t;
    typedef logic [TAG_W-1:0]       tag_t;
    typedef logic [INDEX_BITS-1:0]  index_t;
    typedef logic [OFFSET_BITS-1:0] offset_t;
    typedef logic [BLOCK_W-1:0]     block_t;
    typedef logic [MADDR_W-1:0]     maddr_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        FILL      = 2'd3
    } state_e;

    function automatic tag_t addr_tag(input addr_t a);
        return a[TAG_LSB +: TAG_W];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[INDEX_LSB +: INDEX_BITS];
    endfunction

    function automatic offset_t addr_offset(input addr_t a);
        return a[OFFSET_LSB +: OFFSET_BITS];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: data/tag arrays (never cleared) plus valid/dirty bits cleared on reset.
module dcache_array
    import dcache_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  index_t  rd_index_i,
    output block_t  rd_block_o,
    output tag_t    rd_tag_o,
    output logic    rd_valid_o,
    output logic    rd_dirty_o,
    input  logic    wr_en_i,
    input  index_t  wr_index_i,
    input  offset_t wr_offset_i,
    input  byte_t   wr_data_i,
    input  logic    fill_en_i,
    input  index_t  fill_index_i,
    input  tag_t    fill_tag_i,
    input  block_t  fill_block_i
);

    block_t               data_q [NUM_LINES];
    tag_t                 tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    assign rd_block_o = data_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];

    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            data_q[fill_index_i] <= fill_block_i;
            tag_q[fill_index_i]  <= fill_tag_i;
        end else if (wr_en_i) begin
            data_q[wr_index_i][int'(wr_offset_i)*DATA_W +: DATA_W] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fill_index_i] <= 1'b1;
            dirty_q[fill_index_i] <= 1'b0;
        end else if (wr_en_i) begin
            dirty_q[wr_index_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller: FSM, hit logic, memory port.
// Optional DCACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [ADDR_W-1:0]  ADDRESS,
    input  logic [DATA_W-1:0]  WRITEDATA,
    output logic [DATA_W-1:0]  READDATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [MADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]        HIT_COUNT,
    output logic [15:0]        MISS_COUNT
`endif
);

    state_e state_q, state_d;
    logic   first_q, first_d;
    logic   mem_read_q, mem_read_d;
    logic   mem_write_q, mem_write_d;
    maddr_t mem_addr_q, mem_addr_d;
    block_t mem_wdata_q, mem_wdata_d;
    maddr_t miss_addr_q, miss_addr_d;
    block_t fill_blk_q, fill_blk_d;

    tag_t    cpu_tag;
    index_t  cpu_index;
    offset_t cpu_offset;
    block_t  rd_block;
    tag_t    rd_tag;
    logic    rd_valid, rd_dirty;
    logic    access, hit, idle_hit, miss, mem_done;

    assign cpu_tag    = addr_tag(ADDRESS);
    assign cpu_index  = addr_index(ADDRESS);
    assign cpu_offset = addr_offset(ADDRESS);

    assign access   = READ | WRITE;
    assign hit      = rd_valid & (rd_tag == cpu_tag);
    assign idle_hit = (state_q == IDLE) & hit;
    assign miss     = (state_q == IDLE) & access & ~hit;
    // The first cycle of a memory state is ignored so a late-rising MEM_BUSYWAIT is never taken as done.
    assign mem_done = ~first_q & ~MEM_BUSYWAIT;

    assign BUSYWAIT      = ~RESET & access & ~idle_hit;
    assign READDATA      = (~RESET & READ & ~WRITE & idle_hit)
                           ? rd_block[int'(cpu_offset)*DATA_W +: DATA_W] : '0;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;

    dcache_array u_array (
        .clk_i        (CLK),
        .rst_i        (RESET),
        .rd_index_i   (cpu_index),
        .rd_block_o   (rd_block),
        .rd_tag_o     (rd_tag),
        .rd_valid_o   (rd_valid),
        .rd_dirty_o   (rd_dirty),
        .wr_en_i      (~RESET & WRITE & idle_hit),
        .wr_index_i   (cpu_index),
        .wr_offset_i  (cpu_offset),
        .wr_data_i    (WRITEDATA),
        .fill_en_i    (~RESET & (state_q == FILL)),
        .fill_index_i (miss_addr_q[INDEX_BITS-1:0]),
        .fill_tag_i   (miss_addr_q[MADDR_W-1 -: TAG_W]),
        .fill_block_i (fill_blk_q)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (miss) state_d = rd_dirty ? WRITEBACK : FETCH;
            WRITEBACK: if (mem_done) state_d = FETCH;
            FETCH:     if (mem_done) state_d = FILL;
            FILL:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        first_d = (state_d != state_q);
    end

    // Memory-side outputs are registered; victim and miss address are captured on leaving IDLE
    // so the transaction completes even if the CPU misbehaves mid-miss.
    always_comb begin
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miss_addr_d = miss_addr_q;
        fill_blk_d  = fill_blk_q;
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    miss_addr_d = {cpu_tag, cpu_index};
                    if (rd_dirty) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = {rd_tag, cpu_index};
                        mem_wdata_d = rd_block;
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = {cpu_tag, cpu_index};
                    end
                end
            end
            WRITEBACK: begin
                if (mem_done) begin
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = miss_addr_q;
                end
            end
            FETCH: begin
                if (mem_done) begin
                    mem_read_d = 1'b0;
                    fill_blk_d = MEM_READDATA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            miss_addr_q <= '0;
            fill_blk_q  <= '0;
        end else begin
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_addr_q <= miss_addr_d;
            fill_blk_q  <= fill_blk_d;
        end
    end

    rd_wr_exclusive_a: assert property (@(posedge CLK) disable iff (RESET) !(READ && WRITE));

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        refill_pending_q, refill_pending_d;

    // The hit that completes a miss is not a hit of its own; refill_pending masks it.
    always_comb begin
        hit_cnt_d        = hit_cnt_q;
        miss_cnt_d       = miss_cnt_q;
        refill_pending_d = refill_pending_q;
        if (miss && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        if (access && idle_hit && !refill_pending_q && hit_cnt_q != 16'hFFFF)
            hit_cnt_d = hit_cnt_q + 16'd1;
        if (state_q == FILL)      refill_pending_d = 1'b1;
        else if (state_q == IDLE) refill_pending_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q        <= '0;
            miss_cnt_q       <= '0;
            refill_pending_q <= 1'b0;
        end else begin
            hit_cnt_q        <= hit_cnt_d;
            miss_cnt_q       <= miss_cnt_d;
            refill_pending_q <= refill_pending_d;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule
